urv_ahb_arbiter: RTL

URV_AHB_ARBITER -- requirements
Module: urv_ahb_arbiter

---
 rtl/urv_ahb_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/urv_ahb_arbiter.sv
// Two-master AHB-Lite arbiter: M0 (exec data) has priority, M1 (fetch/debug) is
// protected from starvation; completions of a master that loses its next request are withheld.
module urv_ahb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] m0_haddr,
  input  logic [1:0]  m0_htrans,
  input  logic        m0_hwrite,
  input  logic [2:0]  m0_hsize,
  input  logic [31:0] m0_hwdata,
  output logic        m0_hready,
  output logic [31:0] m0_hrdata,

  input  logic [31:0] m1_haddr,
  input  logic [1:0]  m1_htrans,
  input  logic        m1_hwrite,
  input  logic [2:0]  m1_hsize,
  input  logic [31:0] m1_hwdata,
  output logic        m1_hready,
  output logic [31:0] m1_hrdata,

  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,

  output logic [1:0]  dphase_owner_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] req;
  logic [1:0] grant;
  logic [1:0] hready_m;
  logic [1:0] owner_reg;
  logic [3:0] starve_cnt_reg;
  logic       starving;
  logic       contended;
  logic [31:0] rdata_m [2];

  // Requests are masked during reset so the slave port sees IDLE immediately.
  assign req[0] = rst_i & m0_htrans[1];
  assign req[1] = rst_i & m1_htrans[1];

  assign contended = req[0] & req[1];
  assign starving  = (starve_cnt_reg == LIMIT);

  assign grant[1] = req[1] & (~req[0] | starving);
  assign grant[0] = req[0] & ~grant[1];

  always_comb begin
    HTRANS = 2'b00;
    HADDR  = 32'h8000_0000;
    HWRITE = 1'b0;
    HSIZE  = 3'h2;
    if (grant[0]) begin
      HTRANS = m0_htrans;
      HADDR  = m0_haddr;
      HWRITE = m0_hwrite;
      HSIZE  = m0_hsize;
    end else if (grant[1]) begin
      HTRANS = m1_htrans;
      HADDR  = m1_haddr;
      HWRITE = m1_hwrite;
      HSIZE  = m1_hsize;
    end
  end

  always_comb begin
    HWDATA = 32'h0;
    if (owner_reg[0]) begin
      HWDATA = m0_hwdata;
    end else if (owner_reg[1]) begin
      HWDATA = m1_hwdata;
    end
  end

  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

  // owner_reg is one-hot per master (01 = M0, 10 = M1), so the grant vector loads it directly.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_reg      <= 2'b00;
      starve_cnt_reg <= 4'd0;
    end else if (HREADY) begin
      owner_reg <= grant;
      if (contended) begin
        if (grant[1]) begin
          starve_cnt_reg <= 4'd0;
        end else if (!starving) begin
          starve_cnt_reg <= starve_cnt_reg + 4'd1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      logic        pend_reg;
      logic [31:0] hold_reg;
      logic        hready_loc;
      logic        withhold;

      always_comb begin
        if (pend_reg) begin
          hready_loc = ~req[gi] | (grant[gi] & HREADY);
        end else if (owner_reg[gi]) begin
          hready_loc = HREADY & (~req[gi] | grant[gi]);
        end else begin
          hready_loc = ~req[gi] | (grant[gi] & HREADY);
        end
      end

      // Data phase finished but the master's next address lost: park the read data.
      assign withhold = owner_reg[gi] & HREADY & req[gi] & ~grant[gi];

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          pend_reg <= 1'b0;
          hold_reg <= 32'h0;
        end else if (withhold) begin
          pend_reg <= 1'b1;
          hold_reg <= HRDATA;
        end else if (hready_loc) begin
          pend_reg <= 1'b0;
        end
      end

      assign hready_m[gi] = hready_loc;
      assign rdata_m[gi]  = pend_reg ? hold_reg : HRDATA;
    end
  endgenerate

  assign m0_hready      = hready_m[0];
  assign m1_hready      = hready_m[1];
  assign m0_hrdata      = rdata_m[0];
  assign m1_hrdata      = rdata_m[1];
  assign dphase_owner_o = owner_reg;

endmodule
